// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite renderer.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } anim_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Coordinate width large enough for the bigger screen dimension.
    localparam int COORD_W = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation controller: frame_tick edge detector, tick counter and
// IDLE/PLAY/DONE playback FSM. frame_idx only moves on frame_tick or
// anim_start, so tick-driven frame changes land at the top of a frame.
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8,
    parameter int FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic               anim_start,
    input  logic               anim_loop,
    output logic [FW-1:0]      frame_idx,
    output logic               anim_busy
);

    localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);

    anim_state_t   state_r, state_n;
    logic [FW-1:0] frame_r, frame_n;
    logic [TW-1:0] tick_r, tick_n;
    logic          origin_r;
    logic          origin_s;
    logic          frame_tick_s;
    logic          busy_r;

    // Detect the first cycle at the screen origin and compute the next FSM state.
    always_comb begin
        origin_s     = (draw_x == {COORD_W{1'b0}}) && (draw_y == {COORD_W{1'b0}});
        frame_tick_s = origin_s & ~origin_r;
        state_n      = state_r;
        frame_n      = frame_r;
        tick_n       = tick_r;
        if (anim_start) begin
            // A restart takes priority over any simultaneous frame_tick.
            state_n = PLAY;
            frame_n = {FW{1'b0}};
            tick_n  = {TW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    frame_n = {FW{1'b0}};
                end
                PLAY: begin
                    if (frame_tick_s) begin
                        if (tick_r == TICK_LAST) begin
                            tick_n = {TW{1'b0}};
                            if (frame_r == FRAME_LAST) begin
                                if (anim_loop) begin
                                    frame_n = {FW{1'b0}};
                                end else begin
                                    state_n = DONE;
                                end
                            end else begin
                                frame_n = frame_r + FW'(1'b1);
                            end
                        end else begin
                            tick_n = tick_r + TW'(1'b1);
                        end
                    end else begin
                        tick_n = tick_r;
                    end
                end
                DONE: begin
                    frame_n = frame_r;
                end
                default: begin
                    state_n = IDLE;
                    frame_n = {FW{1'b0}};
                    tick_n  = {TW{1'b0}};
                end
            endcase
        end
    end

    // State, frame, tick counter and origin-edge registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            frame_r  <= {FW{1'b0}};
            tick_r   <= {TW{1'b0}};
            origin_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            frame_r  <= frame_n;
            tick_r   <= tick_n;
            origin_r <= origin_s;
            busy_r   <= (state_n == PLAY);
        end
    end

    assign frame_idx = frame_r;
    assign anim_busy = busy_r;

endmodule

// File: rtl/sprite_renderer.sv
// Positioned, integer-scaled, animated sprite renderer.
// Pipeline: S1 address register, S2 synchronous ROM read, S3 pixel output.
// Optional feature macro: SPRITE_FLIP_EN adds a flip_h input that mirrors
// the sprite horizontally.
module sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int FRAMES      = 4,
    parameter int SCALE_SH    = 0,
    parameter int IDX_W       = 2,
    parameter int TRANSP_IDX  = 0,
    parameter int FRAME_TICKS = 8,
    parameter int AW          = $clog2(FRAMES * SPR_W * SPR_H),
    parameter int FW          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               blank,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
`ifdef SPRITE_FLIP_EN
    input  logic               flip_h,
`endif
    input  logic               anim_start,
    input  logic               anim_loop,
    output logic               anim_busy,
    output logic [FW-1:0]      frame_idx,
    output logic [AW-1:0]      rom_addr,
    input  logic [IDX_W-1:0]   rom_q,
    output logic [IDX_W-1:0]   pix_idx,
    output logic               pix_hit
);

    localparam int DW = COORD_W + 1;
    localparam logic [DW-1:0]    SPR_W_D    = DW'(SPR_W);
    localparam logic [DW-1:0]    SPR_H_D    = DW'(SPR_H);
    localparam logic [AW-1:0]    SPR_W_A    = AW'(SPR_W);
    localparam logic [AW-1:0]    FRAME_SZ_A = AW'(SPR_W * SPR_H);
    localparam logic [IDX_W-1:0] TRANSP_L   = IDX_W'(TRANSP_IDX);

    logic [DW-1:0]    dx_s, dy_s, tx_s, ty_s, tx_eff_s;
    logic             inside_s;
    logic [AW-1:0]    addr_s;
    logic             hit_s;
    logic [IDX_W-1:0] idx_s;

    logic [AW-1:0]    rom_addr_r;
    logic             inside_s1_r, blank_s1_r;
    logic             inside_s2_r, blank_s2_r;
    logic             pix_hit_r;
    logic [IDX_W-1:0] pix_idx_r;

    sprite_anim_ctrl #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS),
        .FW          (FW)
    ) u_anim (
        .clk        (vga_clk),
        .reset_n    (reset_n),
        .draw_x     (DrawX),
        .draw_y     (DrawY),
        .anim_start (anim_start),
        .anim_loop  (anim_loop),
        .frame_idx  (frame_idx),
        .anim_busy  (anim_busy)
    );

    // Map the screen pixel into sprite-local texel coordinates and a ROM address.
    always_comb begin
        dx_s     = {1'b0, DrawX} - {1'b0, pos_x};
        dy_s     = {1'b0, DrawY} - {1'b0, pos_y};
        tx_s     = dx_s >> SCALE_SH;
        ty_s     = dy_s >> SCALE_SH;
        inside_s = !dx_s[DW-1] && !dy_s[DW-1] && (tx_s < SPR_W_D) && (ty_s < SPR_H_D);
`ifdef SPRITE_FLIP_EN
        if (flip_h) begin
            tx_eff_s = SPR_W_D - DW'(1'b1) - tx_s;
        end else begin
            tx_eff_s = tx_s;
        end
`else
        tx_eff_s = tx_s;
`endif
        addr_s = AW'(frame_idx) * FRAME_SZ_A + AW'(ty_s) * SPR_W_A + AW'(tx_eff_s);
    end

    // Decide opacity of the texel returned by the ROM for the S2 pixel.
    always_comb begin
        hit_s = inside_s2_r && blank_s2_r && (rom_q != TRANSP_L);
        if (hit_s) begin
            idx_s = rom_q;
        end else begin
            idx_s = {IDX_W{1'b0}};
        end
    end

    // Three-stage address/pixel pipeline with its valid bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r  <= {AW{1'b0}};
            inside_s1_r <= 1'b0;
            blank_s1_r  <= 1'b0;
            inside_s2_r <= 1'b0;
            blank_s2_r  <= 1'b0;
            pix_hit_r   <= 1'b0;
            pix_idx_r   <= {IDX_W{1'b0}};
        end else begin
            // Outside the box the address is a don't-care, so it is simply held.
            if (inside_s) begin
                rom_addr_r <= addr_s;
            end
            inside_s1_r <= inside_s;
            blank_s1_r  <= blank;
            inside_s2_r <= inside_s1_r;
            blank_s2_r  <= blank_s1_r;
            pix_hit_r   <= hit_s;
            pix_idx_r   <= idx_s;
        end
    end

    assign rom_addr = rom_addr_r;
    assign pix_hit  = pix_hit_r;
    assign pix_idx  = pix_idx_r;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: two instances (scale 1x and 2x)
// share stimulus; expected pixels are queued on drive and popped on output.
module tb_sprite_renderer;

    localparam int FT = 2;
    localparam int FR = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] draw_x = 10'd700, draw_y = 10'd400, pos_x = 10'd0, pos_y = 10'd0;
    logic       blank = 1'b0, anim_start = 1'b0, anim_loop = 1'b0, flip_h = 1'b0;

    logic [9:0] rom_addr0, rom_addr1;
    logic [1:0] rom_q0, rom_q1, pix_idx0, pix_idx1, frame0, frame1;
    logic       pix_hit0, pix_hit1, busy0, busy1;

    logic [1:0] mem [0:1023];

    int   checks = 0;
    int   failures = 0;
    int   m_state, m_frame, m_tick;
    bit   m_org;
    logic [9:0] ea0, ea1;
    logic [2:0] q0[$];
    logic [2:0] q1[$];

    always #5 clk = ~clk;

    // Synchronous sprite ROMs, one read port per instance.
    always @(posedge clk) begin
        rom_q0 <= mem[rom_addr0];
        rom_q1 <= mem[rom_addr1];
    end

    sprite_renderer #(.SPR_W(16), .SPR_H(16), .FRAMES(FR), .SCALE_SH(0), .IDX_W(2),
                      .TRANSP_IDX(0), .FRAME_TICKS(FT)) dut0 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y),
`ifdef SPRITE_FLIP_EN
        .flip_h(flip_h),
`endif
        .anim_start(anim_start), .anim_loop(anim_loop), .anim_busy(busy0), .frame_idx(frame0),
        .rom_addr(rom_addr0), .rom_q(rom_q0), .pix_idx(pix_idx0), .pix_hit(pix_hit0));

    sprite_renderer #(.SPR_W(16), .SPR_H(16), .FRAMES(FR), .SCALE_SH(1), .IDX_W(2),
                      .TRANSP_IDX(0), .FRAME_TICKS(FT)) dut1 (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(draw_x), .DrawY(draw_y), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y),
`ifdef SPRITE_FLIP_EN
        .flip_h(flip_h),
`endif
        .anim_start(anim_start), .anim_loop(anim_loop), .anim_busy(busy1), .frame_idx(frame1),
        .rom_addr(rom_addr1), .rom_q(rom_q1), .pix_idx(pix_idx1), .pix_hit(pix_hit1));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Returns {inside, address} for a given scale, pixel, position and frame.
    function automatic logic [10:0] model_px(input int sh, input int x, input int y,
                                             input int px, input int py, input int fr,
                                             input bit flip);
        int dx, dy, tx, ty;
        dx = x - px;
        dy = y - py;
        if (dx < 0 || dy < 0) return 11'd0;
        tx = dx >> sh;
        ty = dy >> sh;
        if (tx >= 16 || ty >= 16) return 11'd0;
        if (flip) tx = 15 - tx;
        return {1'b1, 10'(fr * 256 + ty * 16 + tx)};
    endfunction

    function automatic logic [2:0] exp_pix(input logic [10:0] r, input logic bl);
        logic [1:0] t;
        t = mem[r[9:0]];
        if (r[10] && bl && t != 2'd0) return {1'b1, t};
        return 3'b000;
    endfunction

    task automatic run_cycle();
        logic [10:0] r0, r1;
        logic [2:0]  e;
        bit          org, tick;
        r0 = model_px(0, int'(draw_x), int'(draw_y), int'(pos_x), int'(pos_y), m_frame, flip_h);
        r1 = model_px(1, int'(draw_x), int'(draw_y), int'(pos_x), int'(pos_y), m_frame, flip_h);
        q0.push_back(exp_pix(r0, blank));
        q1.push_back(exp_pix(r1, blank));
        if (r0[10]) ea0 = r0[9:0];
        if (r1[10]) ea1 = r1[9:0];
        org   = (draw_x == 10'd0) && (draw_y == 10'd0);
        tick  = org && !m_org;
        m_org = org;
        if (anim_start) begin
            m_state = 1; m_frame = 0; m_tick = 0;
        end else if (m_state == 1 && tick) begin
            if (m_tick == FT - 1) begin
                m_tick = 0;
                if (m_frame == FR - 1) begin
                    if (anim_loop) m_frame = 0;
                    else m_state = 2;
                end else begin
                    m_frame++;
                end
            end else begin
                m_tick++;
            end
        end
        @(posedge clk);
        #1;
        check_val("rom_addr0", 32'(rom_addr0), 32'(ea0));
        check_val("rom_addr1", 32'(rom_addr1), 32'(ea1));
        check_val("frame_idx", 32'(frame0), 32'(m_frame));
        check_val("anim_busy", 32'(busy0), 32'(m_state == 1));
        check_val("frame_idx1", 32'(frame1), 32'(m_frame));
        if (q0.size() == 3) begin
            e = q0.pop_front();
            check_val("pix_hit0", 32'(pix_hit0), 32'(e[2]));
            check_val("pix_idx0", 32'(pix_idx0), 32'(e[1:0]));
        end
        if (q1.size() == 3) begin
            e = q1.pop_front();
            check_val("pix_hit1", 32'(pix_hit1), 32'(e[2]));
            check_val("pix_idx1", 32'(pix_idx1), 32'(e[1:0]));
        end
    endtask

    task automatic drive_px(input int x, input int y, input bit bl);
        draw_x = 10'(x);
        draw_y = 10'(y);
        blank  = bl;
        run_cycle();
    endtask

    task automatic apply_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_rom_addr", 32'(rom_addr0), 32'd0);
        check_val("rst_pix_idx", 32'(pix_idx0), 32'd0);
        check_val("rst_pix_hit", 32'(pix_hit0), 32'd0);
        check_val("rst_pix_hit1", 32'(pix_hit1), 32'd0);
        check_val("rst_frame", 32'(frame0), 32'd0);
        check_val("rst_busy", 32'(busy0), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_state = 0; m_frame = 0; m_tick = 0; m_org = 1'b0;
        ea0 = 10'd0; ea1 = 10'd0;
        q0.delete(); q1.delete();
        repeat (2) begin
            q0.push_back(3'b000);
            q1.push_back(3'b000);
        end
        check_val("rel_pix_hit", 32'(pix_hit0), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 2'((i * 5 + (i >> 4) + 1) % 4);

        apply_reset();

        // Placement at (100,50), 1x scale.
        pos_x = 10'd100; pos_y = 10'd50;
        drive_px(100, 50, 1'b1);
        check_val("place_addr", 32'(rom_addr0), 32'd0);
        drive_px(99, 50, 1'b1);
        drive_px(116, 50, 1'b1);
        check_val("place_hit", 32'(pix_hit0), 32'd1);
        check_val("place_idx", 32'(pix_idx0), 32'd1);
        drive_px(115, 65, 1'b1);
        check_val("left_miss", 32'(pix_hit0), 32'd0);
        drive_px(100, 66, 1'b1);
        check_val("right_miss", 32'(pix_hit0), 32'd0);
        drive_px(700, 400, 1'b1);
        drive_px(700, 400, 1'b1);

        // 2x scale, transparency and blanking at (0,0).
        pos_x = 10'd0; pos_y = 10'd0;
        drive_px(3, 5, 1'b1);
        check_val("scale_addr", 32'(rom_addr1), 32'd33);
        drive_px(2, 0, 1'b1);
        drive_px(3, 5, 1'b0);
        check_val("transp_hit", 32'(pix_hit1), 32'd0);
        check_val("transp_idx", 32'(pix_idx1), 32'd0);
        drive_px(31, 31, 1'b1);
        check_val("opaque_hit", 32'(pix_hit1), 32'd1);
        check_val("opaque_idx", 32'(pix_idx1), 32'd2);
        drive_px(40, 2, 1'b1);
        check_val("blank_hit", 32'(pix_hit1), 32'd0);
        drive_px(700, 400, 1'b1);
        drive_px(700, 400, 1'b1);

`ifdef SPRITE_FLIP_EN
        flip_h = 1'b1;
        drive_px(0, 0, 1'b1);
        check_val("flip_addr", 32'(rom_addr0), 32'd15);
        drive_px(4, 1, 1'b1);
        flip_h = 1'b0;
        drive_px(700, 400, 1'b1);
`endif

        // Looped animation.
        anim_loop  = 1'b1;
        anim_start = 1'b1;
        drive_px(5, 5, 1'b1);
        anim_start = 1'b0;
        check_val("loop_start_frame", 32'(frame0), 32'd0);
        check_val("loop_start_busy", 32'(busy0), 32'd1);
        for (int n = 1; n <= 8; n++) begin
            drive_px(0, 0, 1'b1);
            drive_px(0, 0, 1'b1);
            if (n == 4) check_val("frame2_addr", 32'(rom_addr0), 32'd512);
            drive_px(5, 5, 1'b1);
            check_val("loop_frame", 32'(frame0), 32'((n / 2) % 4));
            check_val("loop_busy", 32'(busy0), 32'd1);
        end

        // One-shot playback, then restart coinciding with a frame_tick.
        anim_loop  = 1'b0;
        anim_start = 1'b1;
        drive_px(5, 5, 1'b1);
        anim_start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            drive_px(0, 0, 1'b1);
            drive_px(6, 6, 1'b1);
        end
        check_val("oneshot_frame", 32'(frame0), 32'd3);
        check_val("oneshot_busy", 32'(busy0), 32'd0);
        anim_start = 1'b1;
        drive_px(0, 0, 1'b1);
        anim_start = 1'b0;
        check_val("restart_frame", 32'(frame0), 32'd0);
        check_val("restart_busy", 32'(busy0), 32'd1);
        drive_px(0, 0, 1'b1);
        drive_px(5, 5, 1'b1);

        // Reset in the middle of a line while drawing opaque pixels.
        pos_x = 10'd100; pos_y = 10'd50;
        anim_loop = 1'b1;
        repeat (4) drive_px(101, 50, 1'b1);
        check_val("pre_rst_hit", 32'(pix_hit0), 32'd1);
        apply_reset();
        repeat (5) drive_px(101, 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Parametrised, positioned sprite renderer for the VGA pixel pipeline. Maps the current (DrawX, DrawY) into a movable, integer-scaled sprite box, issues a synchronous sprite-ROM address, and returns an aligned palette index plus hit flag for the downstream compositor. It adds multi-frame animation, with looped or one-shot playback and tear-free frame switching, to the fixed full-screen single-sprite stretch used so far.

## Interface
- SPR_W, 16: sprite width in texels
- SPR_H, 16: sprite height in texels
- FRAMES, 4: animation frames stored back-to-back in ROM
- SCALE_SH, 0: on-screen scale = 2^SCALE_SH pixels per texel
- IDX_W, 2: palette index width
- TRANSP_IDX, 0: palette index treated as transparent
- FRAME_TICKS, 8: video frames per animation step (≥1)
- AW, $clog2(FRAMES*SPR_W*SPR_H): ROM address width (derived)

Ports:
- vga_clk in 1: pixel clock; all logic on posedge
- reset_n in 1: asynchronous, active-low reset
- DrawX, DrawY in 10: current pixel coordinate
- blank in 1: 1 = active video (pixel visible)
- pos_x, pos_y in 10: top-left screen position of sprite
- anim_start in 1: one-cycle pulse, (re)start animation at frame 0
- anim_loop in 1: 1 = wrap after last frame, 0 = one-shot; sampled at each step
- anim_busy out 1: animation in PLAY
- frame_idx out $clog2(FRAMES) (min 1): currently displayed frame
- rom_addr out AW: registered address to synchronous sprite ROM (1-cycle read latency)
- rom_q in IDX_W: ROM data
- pix_idx out IDX_W: palette index, 0 when not hit
- pix_hit out 1: opaque sprite pixel in active video

## Operation
- Local coordinates: dx = {1'b0,DrawX} − {1'b0,pos_x} and dy likewise, each 11 bits. Inside when dx, dy are non-negative, (dx>>SCALE_SH) < SPR_W and (dy>>SCALE_SH) < SPR_H. Off-screen parts clip naturally.
- Address: frame_idx*SPR_W*SPR_H + ty*SPR_W + tx, where tx = dx>>SCALE_SH and ty = dy>>SCALE_SH. When outside the box, rom_addr is unchanged and don't-care.
- Pixel pipeline has three stages: S1 registers rom_addr together with inside and blank; S2 is the ROM read, with inside and blank delayed; S3 registers pix_hit = inside & blank & (rom_q != TRANSP_IDX), and pix_idx = rom_q when hit, else 0.
- frame_tick is a one-cycle pulse on the first cycle with DrawX==0 and DrawY==0; an edge detector prevents repeats.
- Animation FSM:
  - IDLE: frame 0, busy 0.
  - PLAY: busy 1. A tick counter runs 0..FRAME_TICKS−1 on frame_tick. On wrap, frame_idx increments. At the last frame, it goes to frame 0 if anim_loop, else to DONE.
  - DONE: holds the last frame, busy 0.
  - anim_start in any state enters PLAY with frame 0 and tick count 0, and wins over a simultaneous frame_tick.
- frame_idx changes only on frame_tick or anim_start, so no mid-frame tearing on tick-driven steps.
- FRAMES=1: the first step goes to DONE, or stays at frame 0 if looping.

## Timing
- Latency: DrawX/DrawY/blank at edge N → pix_idx/pix_hit valid after edge N+3; rom_addr after edge N+1.
- pos_x/pos_y/frame_idx are sampled at S1 along with DrawX.
- Reset (async assert, sync deassert expected from top): rom_addr 0, pix_idx 0, pix_hit 0, pipeline valid bits 0, FSM IDLE, frame_idx 0, anim_busy 0, tick counter 0.
- Reset mid-line: outputs drop to 0 immediately; the first 3 cycles after release give pix_hit 0.

## Configuration
- SPRITE_FLIP_EN defined: adds input port flip_h (1 bit), sampled at S1. When 1, tx becomes SPR_W−1−tx.
- Undefined: no flip_h port, and tx is unmodified.

## Structure
- Package sprite_pkg holds the anim_state_t enum (IDLE, PLAY, DONE) and the shared constants SCREEN_W=640 and SCREEN_H=480.
- One sub-module, sprite_anim_ctrl, contains the frame_tick detector, tick counter and FSM, and outputs frame_idx and anim_busy.
- The address/pixel pipeline lives in the top module; ROM and palette remain external.

## Test plan
- Reset: assert reset_n=0 mid-line. Required: all outputs 0 immediately, and pix_hit=0 for the first 3 cycles after release.
- Placement: pos=(100,50), SCALE_SH=0, ROM texel(0,0)=1. Pixel (100,50) → rom_addr=0, then pix_hit=1 and pix_idx=1 three cycles later. Pixels (99,50) and (116,50) → pix_hit=0.
- Scale and transparency: SCALE_SH=1, pos=(0,0). Pixel (3,5) → rom_addr=2*16+1=33. A texel equal to TRANSP_IDX gives pix_hit=0 and pix_idx=0; the same pixel with blank=0 also gives pix_hit=0.
- Animation loop: FRAME_TICKS=2, anim_loop=1, anim_start pulse. Required: frame_idx sequence 0,1,2,3,0 advancing every 2 frame_ticks, anim_busy=1 throughout. Pixel (0,0) in frame 2 addresses 512.
- One-shot and restart: anim_loop=0. Required: state reaches DONE holding frame 3 with anim_busy=0. Then anim_start on the same cycle as a frame_tick gives frame_idx=0 and PLAY.
- Flip (SPRITE_FLIP_EN): flip_h=1, pos=(0,0). Pixel (0,0) → rom_addr=15.
